nano_mem_arbiter: RTL and testbench

//  Shares one 32-bit memory port between the nano_rv32i instruction-fetch
//  and data-access interfaces. Sits between the core and a unified RAM.

---
 rtl/nano_mem_pkg.sv | 20 ++
 rtl/nano_mem_wdt.sv | 30 +++
 rtl/nano_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_nano_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_mem_pkg.sv
// nano_mem_pkg: shared types and defaults for the nano_rv32i memory arbiter.
package nano_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RESP_I,
      RESP_D
   } arb_state_e;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [3:0]  FETCH_STROBE      = 4'hF;

endpackage

// File: rtl/nano_mem_wdt.sv
// nano_mem_wdt: counts grant cycles without ack and flags the cycle that must abort.
module nano_mem_wdt #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (run_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Fires during the TIMEOUT_CYCLES-th unacknowledged cycle so the abort lands on time.
   assign expired_o = (TIMEOUT_CYCLES != 0) && run_i && (cnt_q == LAST);

endmodule

// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter: shares one 32-bit memory port between fetch and data accesses.
// Define NANO_ARB_RR_EN for round-robin arbitration; otherwise data wins ties.
module nano_mem_arbiter
   import nano_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] i_addr_i,
   input  logic        i_rd_i,
   output logic [31:0] i_data_o,
   output logic        i_ready_o,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_data_i,
   input  logic [3:0]  d_rd_i,
   input  logic [3:0]  d_we_i,
   output logic [31:0] d_data_o,
   output logic        d_ready_o,
   output logic        err_o,
   output logic        m_req_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   output logic [3:0]  m_we_o,
   output logic [3:0]  m_rd_o,
   input  logic [31:0] m_data_i,
   input  logic        m_ack_i
);

   arb_state_e  state_q, state_d;
   grant_e      pick;
   logic        i_req, d_req, in_grant, expired;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  we_q, rd_q;
   logic        err_q;

   assign i_req    = i_rd_i;
   assign d_req    = (|d_rd_i) | (|d_we_i);
   assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

   nano_mem_wdt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdt (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (state_q == IDLE),
      .run_i    (in_grant && !m_ack_i),
      .expired_o(expired)
   );

`ifdef NANO_ARB_RR_EN
   grant_e last_grant_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_grant_q <= GNT_I;
      end else if (state_q == IDLE && (i_req || d_req)) begin
         last_grant_q <= pick;
      end
   end

   assign pick = (i_req && d_req) ? ((last_grant_q == GNT_I) ? GNT_D : GNT_I)
                                  : (d_req ? GNT_D : GNT_I);
`else
   assign pick = d_req ? GNT_D : GNT_I;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_req || d_req) state_d = (pick == GNT_D) ? GRANT_D : GRANT_I;
         GRANT_I: if (m_ack_i || expired) state_d = RESP_I;
         GRANT_D: if (m_ack_i || expired) state_d = RESP_D;
         RESP_I:  state_d = IDLE;
         RESP_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Requester inputs are sampled only at grant; the ack takes priority over the abort.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (state_d == GRANT_I) begin
                  addr_q  <= i_addr_i;
                  wdata_q <= '0;
                  we_q    <= '0;
                  rd_q    <= FETCH_STROBE;
               end else if (state_d == GRANT_D) begin
                  addr_q  <= d_addr_i;
                  wdata_q <= d_data_i;
                  we_q    <= d_we_i;
                  rd_q    <= d_rd_i;
               end
            end
            GRANT_I: begin
               if (m_ack_i) begin
                  rdata_q <= m_data_i;
                  err_q   <= 1'b0;
               end else if (expired) begin
                  rdata_q <= NOP_INSTR;
                  err_q   <= 1'b1;
               end
            end
            GRANT_D: begin
               if (m_ack_i) begin
                  rdata_q <= (|we_q) ? 32'd0 : m_data_i;
                  err_q   <= 1'b0;
               end else if (expired) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_req_o   = in_grant;
   assign m_addr_o  = in_grant ? addr_q  : '0;
   assign m_data_o  = in_grant ? wdata_q : '0;
   assign m_we_o    = in_grant ? we_q    : '0;
   assign m_rd_o    = in_grant ? rd_q    : '0;
   assign i_ready_o = (state_q == RESP_I);
   assign d_ready_o = (state_q == RESP_D);
   assign i_data_o  = i_ready_o ? rdata_q : '0;
   assign d_data_o  = d_ready_o ? rdata_q : '0;
   assign err_o     = (i_ready_o | d_ready_o) & err_q;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb_nano_mem_arbiter: transaction-level reference model plus directed vectors for nano_mem_arbiter.
module tb_nano_mem_arbiter;

   localparam int          TIMEOUT = 16;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam int PH_IDLE = 0, PH_MEM = 1, PH_RESP = 2;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [31:0] i_addr_i = '0, d_addr_i = '0, d_data_i = '0, m_data_i = '0;
   logic        i_rd_i = 1'b0, m_ack_i = 1'b0;
   logic [3:0]  d_rd_i = '0, d_we_i = '0;
   logic [31:0] i_data_o, d_data_o, m_addr_o, m_data_o;
   logic        i_ready_o, d_ready_o, err_o, m_req_o;
   logic [3:0]  m_we_o, m_rd_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ack_delay = 0;
   int req_cnt = 0;

   // Reference model state: one outstanding transaction described at the bus level.
   int          ph = PH_IDLE;
   bit          side_d = 1'b0, last_d = 1'b0, r_err = 1'b0;
   logic [31:0] t_addr = '0, t_wdata = '0, r_data = '0;
   logic [3:0]  t_we = '0, t_rd = '0;
   int          age = 0;

   nano_mem_arbiter #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .NOP_INSTR     (NOP)
   ) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .i_addr_i (i_addr_i),
      .i_rd_i   (i_rd_i),
      .i_data_o (i_data_o),
      .i_ready_o(i_ready_o),
      .d_addr_i (d_addr_i),
      .d_data_i (d_data_i),
      .d_rd_i   (d_rd_i),
      .d_we_i   (d_we_i),
      .d_data_o (d_data_o),
      .d_ready_o(d_ready_o),
      .err_o    (err_o),
      .m_req_o  (m_req_o),
      .m_addr_o (m_addr_o),
      .m_data_o (m_data_o),
      .m_we_o   (m_we_o),
      .m_rd_o   (m_rd_o),
      .m_data_i (m_data_i),
      .m_ack_i  (m_ack_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ird, input logic [31:0] ia, input logic [3:0] drd,
                                input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dd);
      i_rd_i   = ird;
      i_addr_i = ia;
      d_rd_i   = drd;
      d_we_i   = dwe;
      d_addr_i = da;
      d_data_i = dd;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Waits for the chosen ready pulse, drops that request in the ready cycle, reports latency.
   task automatic waitReady(input bit want_d, input int budget, input int c0, output int lat);
      lat = -1;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk_i);
         #1;
         if (want_d ? d_ready_o : i_ready_o) begin
            lat = cyc - c0;
            if (want_d) begin
               d_rd_i = '0;
               d_we_i = '0;
            end else begin
               i_rd_i = 1'b0;
            end
            break;
         end
      end
      if (lat < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL ready_timeout: no %s ready within %0d cycles", want_d ? "data" : "fetch", budget);
      end
   endtask

   // Memory responder: acks on the ack_delay-th cycle of m_req_o; negative means never.
   initial begin
      forever begin
         @(negedge clk_i);
         if (m_req_o) begin
            m_ack_i = (ack_delay >= 0) && (req_cnt == ack_delay);
            req_cnt++;
         end else begin
            m_ack_i = 1'b0;
            req_cnt = 0;
         end
      end
   end

   // Reference model: arbitration, one access at a time, response cycle, one idle cycle.
   initial begin
      forever begin
         @(posedge clk_i or negedge rst_n_i);
         if (!rst_n_i) begin
            ph     = PH_IDLE;
            last_d = 1'b0;
         end else if (ph == PH_IDLE) begin
            if (i_rd_i || (d_rd_i != 0) || (d_we_i != 0)) begin
`ifdef NANO_ARB_RR_EN
               side_d = ((d_rd_i != 0) || (d_we_i != 0)) && (!i_rd_i || !last_d);
`else
               side_d = (d_rd_i != 0) || (d_we_i != 0);
`endif
               last_d  = side_d;
               t_addr  = side_d ? d_addr_i : i_addr_i;
               t_wdata = side_d ? d_data_i : 32'd0;
               t_we    = side_d ? d_we_i : 4'd0;
               t_rd    = side_d ? d_rd_i : 4'hF;
               age     = 0;
               ph      = PH_MEM;
            end
         end else if (ph == PH_MEM) begin
            if (m_ack_i) begin
               r_err  = 1'b0;
               r_data = (side_d && t_we != 0) ? 32'd0 : m_data_i;
               ph     = PH_RESP;
            end else begin
               age++;
               if (TIMEOUT != 0 && age == TIMEOUT) begin
                  r_err  = 1'b1;
                  r_data = side_d ? 32'd0 : NOP;
                  ph     = PH_RESP;
               end
            end
         end else begin
            ph = PH_IDLE;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial begin
      logic [72:0] exp_mem;
      logic [66:0] exp_core;
      forever begin
         @(negedge clk_i);
         exp_mem  = '0;
         exp_core = '0;
         if (ph == PH_MEM) exp_mem = {1'b1, t_addr, t_wdata, t_we, t_rd};
         if (ph == PH_RESP) begin
            if (side_d) exp_core = {1'b0, 32'd0, 1'b1, r_data, r_err};
            else        exp_core = {1'b1, r_data, 1'b0, 32'd0, r_err};
         end
         checkOutput("mem_side", {m_req_o, m_addr_o, m_data_o, m_we_o, m_rd_o}, exp_mem);
         checkOutput("core_side", {i_ready_o, i_data_o, d_ready_o, d_data_o, err_o}, exp_core);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] stopped");
   end

   initial begin
      int c0, lat, n, dpulses;
      int order[4];

      tick(2);
      checkOutput("reset_mem", {m_req_o, m_addr_o, m_data_o, m_we_o, m_rd_o}, 0);
      checkOutput("reset_core", {i_ready_o, i_data_o, d_ready_o, d_data_o, err_o}, 0);
      rst_n_i = 1'b1;
      tick(2);

      $display("[TB] fetch with immediate ack");
      m_data_i = 32'h0050_0093; ack_delay = 0;
      applyStimulus(1'b1, 32'h100, 4'h0, 4'h0, 32'h0, 32'h0);
      c0 = cyc;
      tick(1);
      checkOutput("t1_m_req", m_req_o, 1);
      checkOutput("t1_m_addr", m_addr_o, 32'h100);
      checkOutput("t1_m_rd", m_rd_o, 4'hF);
      waitReady(1'b0, 10, c0, lat);
      checkOutput("t1_latency", lat, 2);
      checkOutput("t1_data", i_data_o, 32'h0050_0093);
      checkOutput("t1_err", err_o, 0);
      tick(2);

      $display("[TB] store acked in third cycle");
      m_data_i = 32'hDEAD_BEEF; ack_delay = 2;
      applyStimulus(1'b0, 32'h0, 4'h0, 4'b0011, 32'h2000, 32'hBEEF);
      c0 = cyc;
      tick(1);
      checkOutput("t2_m_we", m_we_o, 4'b0011);
      checkOutput("t2_m_data", m_data_o, 32'hBEEF);
      checkOutput("t2_m_addr", m_addr_o, 32'h2000);
      waitReady(1'b1, 10, c0, lat);
      checkOutput("t2_latency", lat, 4);
      checkOutput("t2_d_data", d_data_o, 0);
      tick(2);

      $display("[TB] simultaneous fetch and load, two rounds");
      m_data_i = 32'h1357_9BDF; ack_delay = 0;
      n = 0;
      for (int r = 0; r < 2; r++) begin
         applyStimulus(1'b1, 32'h200, 4'hF, 4'h0, 32'h3000, 32'h0);
         for (int k = 0; k < 20 && n < 2 * (r + 1); k++) begin
            tick(1);
            if (d_ready_o) begin order[n] = 1; n++; d_rd_i = '0; end
            if (i_ready_o) begin order[n] = 0; n++; i_rd_i = 1'b0; end
         end
         tick(2);
      end
      checkOutput("t3_grants", n, 4);
      checkOutput("t3_r0_first", order[0], 1);
      checkOutput("t3_r0_second", order[1], 0);
      checkOutput("t3_r1_first", order[2], 1);
      checkOutput("t3_r1_second", order[3], 0);

      $display("[TB] fetch timeout");
      m_data_i = 32'h1111_2222; ack_delay = -1;
      applyStimulus(1'b1, 32'h400, 4'h0, 4'h0, 32'h0, 32'h0);
      c0 = cyc;
      waitReady(1'b0, 30, c0, lat);
      checkOutput("t4_latency", lat, 17);
      checkOutput("t4_err", err_o, 1);
      checkOutput("t4_nop", i_data_o, 32'h0000_0013);
      tick(2);

      $display("[TB] ack in the last cycle before timeout");
      m_data_i = 32'h0A0B_0C0D; ack_delay = 15;
      applyStimulus(1'b1, 32'h404, 4'h0, 4'h0, 32'h0, 32'h0);
      c0 = cyc;
      waitReady(1'b0, 30, c0, lat);
      checkOutput("t4b_latency", lat, 17);
      checkOutput("t4b_err", err_o, 0);
      checkOutput("t4b_data", i_data_o, 32'h0A0B_0C0D);
      tick(2);

      $display("[TB] load timeout");
      m_data_i = 32'hFFFF_FFFF; ack_delay = -1;
      applyStimulus(1'b0, 32'h0, 4'h3, 4'h0, 32'h500, 32'h0);
      c0 = cyc;
      waitReady(1'b1, 30, c0, lat);
      checkOutput("t4c_err", err_o, 1);
      checkOutput("t4c_d_data", d_data_o, 0);
      tick(2);

      $display("[TB] reset during data grant");
      applyStimulus(1'b0, 32'h0, 4'hF, 4'h0, 32'h600, 32'h0);
      tick(3);
      #1;
      rst_n_i = 1'b0;
      applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
      #1;
      checkOutput("t5_async_mem", {m_req_o, m_addr_o, m_data_o, m_we_o, m_rd_o}, 0);
      checkOutput("t5_async_core", {i_ready_o, i_data_o, d_ready_o, d_data_o, err_o}, 0);
      #1;
      rst_n_i = 1'b1;
      dpulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         if (d_ready_o) dpulses++;
      end
      checkOutput("t5_no_ready", dpulses, 0);
      m_data_i = 32'h1234_5678; ack_delay = 0;
      applyStimulus(1'b1, 32'h700, 4'h0, 4'h0, 32'h0, 32'h0);
      c0 = cyc;
      waitReady(1'b0, 10, c0, lat);
      checkOutput("t5_latency", lat, 2);
      checkOutput("t5_data", i_data_o, 32'h1234_5678);
      tick(2);

      $display("[TB] address change mid-transaction");
      m_data_i = 32'hCAFE_F00D; ack_delay = 3;
      applyStimulus(1'b0, 32'h0, 4'hF, 4'h0, 32'h4000, 32'h0);
      c0 = cyc;
      tick(2);
      applyStimulus(1'b0, 32'h0, 4'h1, 4'h0, 32'h9000, 32'h0);
      tick(1);
      checkOutput("t6_m_addr", m_addr_o, 32'h4000);
      checkOutput("t6_m_rd", m_rd_o, 4'hF);
      waitReady(1'b1, 10, c0, lat);
      checkOutput("t6_latency", lat, 5);
      checkOutput("t6_data", d_data_o, 32'hCAFE_F00D);
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
